// File: rtl/fpu_arbiter_if.sv
// Requester-side and Fpu-side bus of the shared-Fpu arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the Fpu.
interface fpu_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_res;
    logic                  rsp_nan;
    logic                  busy;
    logic                  fpu_en;
    logic [1:0]            fpu_op;
    logic [31:0]           fpu_operand0;
    logic [31:0]           fpu_operand1;
    logic [31:0]           fpu_res;
    logic                  fpu_nan;

    modport slave (
        input  req, req_op, req_a, req_b, fpu_res, fpu_nan,
        output gnt, rsp_valid, rsp_res, rsp_nan, busy,
               fpu_en, fpu_op, fpu_operand0, fpu_operand1
    );

    modport master (
        output req, req_op, req_a, req_b, fpu_res, fpu_nan,
        input  gnt, rsp_valid, rsp_res, rsp_nan, busy,
               fpu_en, fpu_op, fpu_operand0, fpu_operand1
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Fpu between NUM_REQ requesters,
// one operation in flight, result returned to the owner with a one-cycle valid pulse.
module fpu_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FPU_LATENCY = 1,
    parameter int unsigned IDX_W       = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    fpu_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY + 1) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    owner, owner_d;
    logic [IDX_W-1:0]    last, last_d;
    logic [IDX_W-1:0]    winner, cand;
    logic                found;
    logic [1:0]          op_q, op_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_res_q, rsp_res_d;
    logic                rsp_nan_q, rsp_nan_d;
    logic                fpu_en_q, fpu_en_d;
    logic                busy_q;

    // First requester after the previous winner, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        owner_d     = owner;
        last_d      = last;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_res_d   = rsp_res_q;
        rsp_nan_d   = rsp_nan_q;
        fpu_en_d    = fpu_en_q;

        unique case (state)
            IDLE: begin
                fpu_en_d = 1'b0;
                if (found) begin
                    op_d          = bus.req_op[2*winner +: 2];
                    a_d           = bus.req_a[32*winner +: 32];
                    b_d           = bus.req_b[32*winner +: 32];
                    owner_d       = winner;
                    last_d        = winner;
                    cnt_d         = CNT_W'(FPU_LATENCY);
                    gnt_d[winner] = 1'b1;
                    fpu_en_d      = 1'b1;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                fpu_en_d = 1'b1;
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    rsp_res_d          = bus.fpu_res;
                    rsp_nan_d          = bus.fpu_nan;
                    rsp_valid_d[owner] = 1'b1;
                    fpu_en_d           = 1'b0;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-operation abandons it; no response is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= '0;
            last        <= IDX_W'(NUM_REQ - 1);
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_nan_q   <= 1'b0;
            fpu_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            owner       <= owner_d;
            last        <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_nan_q   <= rsp_nan_d;
            fpu_en_q    <= fpu_en_d;
            busy_q      <= (state_d == BUSY);
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_res      = rsp_res_q;
    assign bus.rsp_nan      = rsp_nan_q;
    assign bus.busy         = busy_q;
    assign bus.fpu_en       = fpu_en_q;
    assign bus.fpu_op       = op_q;
    assign bus.fpu_operand0 = a_q;
    assign bus.fpu_operand1 = b_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: two instances (Fpu latency 1 and 3), each with a behavioural Fpu,
// exercised one at a time and checked against a round-robin / IEEE-single reference model.
module tb_fpu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    int unsigned lat;
    int          tests = 0;
    int          fails = 0;
    int unsigned m_last;

    logic [3:0]   req;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;

    logic [3:0]  gnt_v [2];
    logic [3:0]  rv_v  [2];
    logic [31:0] res_v [2];
    logic [31:0] op0_v [2];
    logic [31:0] op1_v [2];
    logic [1:0]  fop_v [2];
    logic        nan_v [2];
    logic        busy_v[2];
    logic        en_v  [2];

    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    // Behavioural Fpu: {nan, res}; results truncated to single precision.
    function automatic logic [32:0] fpu_fn(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        real ra, rb, rr;
        ra = sp2r(a);
        rb = sp2r(b);
        case (op)
            2'b00:   rr = ra + rb;
            2'b01:   rr = ra - rb;
            2'b10:   rr = ra * rb;
            default: begin
                if (b[30:0] == 31'd0) begin
                    if (a[30:0] == 31'd0) return {1'b1, 32'h7FC00000};
                    return {1'b0, a[31] ^ b[31], 31'h7F800000};
                end
                rr = ra / rb;
            end
        endcase
        return {1'b0, r2sp(rr)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;
        fpu_arbiter_if #(.NUM_REQ(4)) bus ();
        logic [31:0] fres = '0;
        logic        fnan = 1'b0;
        int unsigned fcnt = 0;
        logic [32:0] fo;

        assign bus.req     = (sel == 1'(g)) ? req : 4'b0000;
        assign bus.req_op  = req_op;
        assign bus.req_a   = req_a;
        assign bus.req_b   = req_b;
        assign bus.fpu_res = fres;
        assign bus.fpu_nan = fnan;
        assign fo          = fpu_fn(bus.fpu_op, bus.fpu_operand0, bus.fpu_operand1);

        fpu_arbiter #(.NUM_REQ(4), .FPU_LATENCY(L), .IDX_W(2)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Result appears after L edges with en high; cleared whenever en is low.
        always @(posedge clk) begin
            if (!bus.fpu_en) begin
                fcnt <= 0;
                fres <= '0;
                fnan <= 1'b0;
            end else begin
                if (fcnt < L) fcnt <= fcnt + 1;
                if (fcnt + 1 >= L) begin
                    fres <= fo[31:0];
                    fnan <= fo[32];
                end
            end
        end

        assign gnt_v[g]  = bus.gnt;
        assign rv_v[g]   = bus.rsp_valid;
        assign res_v[g]  = bus.rsp_res;
        assign nan_v[g]  = bus.rsp_nan;
        assign busy_v[g] = bus.busy;
        assign en_v[g]   = bus.fpu_en;
        assign fop_v[g]  = bus.fpu_op;
        assign op0_v[g]  = bus.fpu_operand0;
        assign op1_v[g]  = bus.fpu_operand1;
    end

    logic [3:0]  o_gnt, o_rv;
    logic [31:0] o_res, o_op0, o_op1;
    logic [1:0]  o_fop;
    logic        o_nan, o_busy, o_en;
    assign o_gnt  = sel ? gnt_v[1]  : gnt_v[0];
    assign o_rv   = sel ? rv_v[1]   : rv_v[0];
    assign o_res  = sel ? res_v[1]  : res_v[0];
    assign o_nan  = sel ? nan_v[1]  : nan_v[0];
    assign o_busy = sel ? busy_v[1] : busy_v[0];
    assign o_en   = sel ? en_v[1]   : en_v[0];
    assign o_fop  = sel ? fop_v[1]  : fop_v[0];
    assign o_op0  = sel ? op0_v[1]  : op0_v[0];
    assign o_op1  = sel ? op1_v[1]  : op1_v[0];

    function automatic logic [3:0] onehot(input int unsigned i);
        logic [3:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned rr_pick(input int unsigned prev, input logic [3:0] r);
        for (int unsigned k = 1; k <= 4; k++)
            if (r[(prev + k) % 4]) return (prev + k) % 4;
        return prev;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    function automatic logic [32:0] exp_of(input int unsigned i);
        return fpu_fn(req_op[2*i +: 2], req_a[32*i +: 32], req_b[32*i +: 32]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            req_op[2*i +: 2]  = 2'($urandom);
            req_a[32*i +: 32] = rand_fp();
            req_b[32*i +: 32] = rand_fp();
        end
    endtask

    task automatic wait_gnt(input int budget, output logic [3:0] g, output int n, output bit ok);
        ok = 1'b0;
        g  = '0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            n++;
            if (o_gnt != 4'b0000) begin
                g  = o_gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        req = 4'b0000;
        for (int i = 0; i < 20 && o_busy; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        tests++;
        if ({o_gnt, o_rv, o_busy, o_en} !== 10'd0)
            begin fails++; $display("FAIL reset_ctrl got gnt=%b rv=%b busy=%b en=%b want 0", o_gnt, o_rv, o_busy, o_en); end
        tests++;
        if ({o_res, o_nan, o_fop, o_op0, o_op1} !== 99'd0)
            begin fails++; $display("FAIL reset_data got res=%h nan=%b op=%b a=%h b=%h want 0", o_res, o_nan, o_fop, o_op0, o_op1); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] g;
        int         n, en_cnt;
        bit         ok, bad;
        req_op[1:0]  = 2'b00;
        req_a[31:0]  = 32'h3F800000;
        req_b[31:0]  = 32'h40000000;
        req          = 4'b0001;
        wait_gnt(10, g, n, ok);
        req = 4'b0000;
        tests++;
        if (!ok || g !== 4'b0001) begin fails++; $display("FAIL single_gnt got %b want 0001", g); end
        tests++;
        if ({o_fop, o_op0, o_op1} !== {2'b00, 32'h3F800000, 32'h40000000})
            begin fails++; $display("FAIL single_bus got op=%b a=%h b=%h", o_fop, o_op0, o_op1); end
        en_cnt = o_en ? 1 : 0;
        bad    = 1'b0;
        for (int j = 1; j <= int'(lat); j++) begin
            tick();
            if (o_en) en_cnt++;
            if (o_gnt != 4'b0000 || o_rv != 4'b0000) bad = 1'b1;
        end
        tick();
        tests++;
        if (en_cnt != int'(lat) + 1 || o_en !== 1'b0)
            begin fails++; $display("FAIL single_en_len got %0d en=%b want %0d", en_cnt, o_en, lat + 1); end
        tests++;
        if (bad) begin fails++; $display("FAIL single_pulse got stray gnt/rsp_valid during op want none"); end
        tests++;
        if (o_rv !== 4'b0001 || o_res !== 32'h40400000 || o_nan !== 1'b0)
            begin fails++; $display("FAIL single_rsp got rv=%b res=%h nan=%b want 0001 40400000 0", o_rv, o_res, o_nan); end
        tick();
        tests++;
        if (o_rv !== 4'b0000 || o_res !== 32'h40400000)
            begin fails++; $display("FAIL single_hold got rv=%b res=%h want 0000 40400000", o_rv, o_res); end
        m_last = 0;
    endtask

    task automatic test_late_arrivals();
        logic [3:0] g;
        int         n;
        bit         ok;
        rand_ops();
        req = 4'b0100;
        wait_gnt(10, g, n, ok);
        tests++;
        if (!ok || g !== 4'b0100) begin fails++; $display("FAIL late_first got %b want 0100", g); end
        req = 4'b1010;
        wait_gnt(3 * int'(lat) + 10, g, n, ok);
        tests++;
        if (!ok || g !== 4'b1000 || n != int'(lat) + 2)
            begin fails++; $display("FAIL late_second got %b after %0d want 1000 after %0d", g, n, lat + 2); end
        req = 4'b0010;
        wait_gnt(3 * int'(lat) + 10, g, n, ok);
        tests++;
        if (!ok || g !== 4'b0010) begin fails++; $display("FAIL late_third got %b want 0010", g); end
        m_last = 1;
        drain();
    endtask

    task automatic test_nan();
        logic [3:0]  g;
        logic [32:0] e;
        int          n;
        bit          ok;
        req_op[1:0] = 2'b11;
        req_a[31:0] = 32'h00000000;
        req_b[31:0] = 32'h00000000;
        req         = 4'b0001;
        wait_gnt(10, g, n, ok);
        req = 4'b0000;
        for (int j = 0; j <= int'(lat); j++) tick();
        tests++;
        if (!ok || o_rv !== 4'b0001 || o_nan !== 1'b1 || o_res !== 32'h7FC00000)
            begin fails++; $display("FAIL nan_rsp got rv=%b nan=%b res=%h want 0001 1 7fc00000", o_rv, o_nan, o_res); end
        for (int j = 0; j < 3; j++) tick();
        tests++;
        if (o_nan !== 1'b1 || o_rv !== 4'b0000)
            begin fails++; $display("FAIL nan_hold got nan=%b rv=%b want 1 0000", o_nan, o_rv); end
        req_op[1:0] = 2'b00;
        req_a[31:0] = rand_fp();
        req_b[31:0] = rand_fp();
        e           = exp_of(0);
        req         = 4'b0001;
        wait_gnt(10, g, n, ok);
        req = 4'b0000;
        for (int j = 0; j <= int'(lat); j++) tick();
        tests++;
        if (!ok || o_rv !== 4'b0001 || {o_nan, o_res} !== e)
            begin fails++; $display("FAIL nan_clear got rv=%b nan=%b res=%h want nan=%b res=%h", o_rv, o_nan, o_res, e[32], e[31:0]); end
        m_last = 0;
    endtask

    task automatic test_operand_change();
        logic [3:0]  g;
        logic [32:0] e;
        logic [31:0] a, b;
        logic [1:0]  op;
        int          n;
        bit          ok, bad;
        rand_ops();
        a   = req_a[63:32];
        b   = req_b[63:32];
        op  = req_op[3:2];
        e   = exp_of(1);
        req = 4'b0010;
        wait_gnt(10, g, n, ok);
        req          = 4'b0000;
        req_a[63:32] = ~a;
        req_op[3:2]  = ~op;
        tests++;
        if (!ok || g !== 4'b0010) begin fails++; $display("FAIL opchg_gnt got %b want 0010", g); end
        bad = 1'b0;
        for (int j = 1; j <= int'(lat); j++) begin
            tick();
            if ({o_fop, o_op0, o_op1} !== {op, a, b}) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL opchg_bus got op=%b a=%h want op=%b a=%h", o_fop, o_op0, op, a); end
        tick();
        tests++;
        if (o_rv !== 4'b0010 || {o_nan, o_res} !== e)
            begin fails++; $display("FAIL opchg_rsp got rv=%b res=%h want 0010 %h", o_rv, o_res, e[31:0]); end
        m_last = 1;
    endtask

    task automatic test_reset_midstream();
        logic [3:0] g;
        int         n;
        bit         ok;
        rand_ops();
        req = 4'b0001;
        wait_gnt(10, g, n, ok);
        req = 4'b0000;
        tick();
        tests++;
        if (o_busy !== 1'b1 || o_en !== 1'b1)
            begin fails++; $display("FAIL midrst_pre got busy=%b en=%b want 1 1", o_busy, o_en); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({o_gnt, o_rv, o_busy, o_en, o_res, o_nan, o_fop, o_op0, o_op1} !== 109'd0)
            begin fails++; $display("FAIL midrst_async got busy=%b en=%b res=%h a=%h want all 0", o_busy, o_en, o_res, o_op0); end
        req = 4'b1111;
        tick();
        rst_n = 1'b1;
        wait_gnt(10, g, n, ok);
        tests++;
        if (!ok || g !== 4'b0001) begin fails++; $display("FAIL midrst_first got %b want 0001", g); end
        m_last = 0;
    endtask

    // Continues from test_reset_midstream with req=1111 held and requester 0 just granted.
    task automatic test_round_robin();
        logic [3:0]  g;
        logic [32:0] e;
        int unsigned prev, nxt;
        int          n, seen;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            e    = exp_of(prev);
            n    = 0;
            seen = 0;
            g    = '0;
            while (g == 4'b0000 && n < 3 * int'(lat) + 10) begin
                tick();
                n++;
                g = o_gnt;
                if (o_rv != 4'b0000) begin
                    seen++;
                    tests++;
                    if (o_rv !== onehot(prev) || {o_nan, o_res} !== e)
                        begin fails++; $display("FAIL rr_rsp got rv=%b res=%h want %b %h", o_rv, o_res, onehot(prev), e[31:0]); end
                end
            end
            nxt = rr_pick(m_last, 4'b1111);
            tests++;
            if (g !== onehot(nxt)) begin fails++; $display("FAIL rr_order got %b want %b", g, onehot(nxt)); end
            tests++;
            if (n != int'(lat) + 2 || seen != 1)
                begin fails++; $display("FAIL rr_spacing got %0d cycles %0d rsp want %0d cycles 1 rsp", n, seen, lat + 2); end
            prev   = nxt;
            m_last = nxt;
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0]  g, r;
        logic [32:0] e;
        int unsigned w;
        int          n;
        bit          ok;
        req = 4'b0000;
        for (int j = 0; j < 3; j++) tick();
        tests++;
        if (o_gnt !== 4'b0000 || o_busy !== 1'b0 || o_en !== 1'b0)
            begin fails++; $display("FAIL rand_idle got gnt=%b busy=%b en=%b want 0", o_gnt, o_busy, o_en); end
        for (int it = 0; it < 24; it++) begin
            rand_ops();
            r   = 4'($urandom_range(1, 15));
            w   = rr_pick(m_last, r);
            e   = exp_of(w);
            req = r;
            wait_gnt(5, g, n, ok);
            tests++;
            if (!ok || g !== onehot(w) || n != 1)
                begin fails++; $display("FAIL rand_gnt req=%b got %b after %0d want %b", r, g, n, onehot(w)); end
            tests++;
            if ({o_fop, o_op0, o_op1} !== {req_op[2*w +: 2], req_a[32*w +: 32], req_b[32*w +: 32]})
                begin fails++; $display("FAIL rand_bus got op=%b a=%h b=%h", o_fop, o_op0, o_op1); end
            req[w] = 1'b0;
            for (int j = 0; j <= int'(lat); j++) tick();
            tests++;
            if (o_rv !== onehot(w) || {o_nan, o_res} !== e)
                begin fails++; $display("FAIL rand_rsp got rv=%b nan=%b res=%h want %b %b %h", o_rv, o_nan, o_res, onehot(w), e[32], e[31:0]); end
            m_last = w;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel    = 1'b0;
        lat    = 1;
        req    = '0;
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        m_last = 3;
        test_reset();
        for (int s = 0; s < 2; s++) begin
            sel    = 1'(s);
            lat    = (s == 0) ? 1 : 3;
            m_last = 3;
            tick();
            test_single();
            test_late_arrivals();
            test_nan();
            test_operand_change();
            test_reset_midstream();
            test_round_robin();
            test_random();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
